spi_rx_fifo: RTL



---
 rtl/spi_pkg.sv | 32 +++
 rtl/spi_rx_fifo.sv | 98 +++++++++
 2 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI receive FIFO and its register-file view.
package spi_pkg;

  localparam int unsigned SPI_FIFO_DEPTH = 16;

  // FIFO_STATUS bit positions
  localparam int unsigned STAT_EMPTY_BIT     = 0;
  localparam int unsigned STAT_FULL_BIT      = 1;
  localparam int unsigned STAT_UNDERFLOW_BIT = 2;
  localparam int unsigned STAT_OVERFLOW_BIT  = 3;
  localparam int unsigned STAT_FLUSH_BIT     = 4;
  localparam int unsigned STAT_CLR_FLAGS_BIT = 5;

  typedef enum logic [7:0] {
    FIFO_DATA    = 8'h10,
    FIFO_COUNT   = 8'h11,
    FIFO_STATUS  = 8'h12,
    FIFO_HIWATER = 8'h13
  } fifo_reg_e;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic full;
    logic empty;
  } fifo_status_t;

  function automatic logic [7:0] status_word(input fifo_status_t s);
    return {4'b0000, s};
  endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// First-word-fall-through byte FIFO from the SPI slave receive path to the
// register file, with occupancy, high-watermark and sticky error flags.
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH  = SPI_FIFO_DEPTH,
  parameter int unsigned DATA_W = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  hiwater,
  output logic              overflow,
  output logic              underflow,
  input  logic              flush,
  input  logic              clr_flags
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [CNT_W-1:0]  count_n, hiwater_n, hw_base;
  logic [DATA_W-1:0] rd_data_n;
  logic              empty_n, full_n, overflow_n, underflow_n;
  logic              push_ok, pop_ok, ovf_evt, udf_evt;

  // Next-state: flush dominates, otherwise push and pop resolve together
  always_comb begin
    push_ok   = 1'b0;
    pop_ok    = 1'b0;
    ovf_evt   = 1'b0;
    udf_evt   = 1'b0;
    wr_ptr_n  = wr_ptr;
    rd_ptr_n  = rd_ptr;
    count_n   = count;
    rd_data_n = rd_data;
    if (flush) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      count_n  = '0;
    end else begin
      pop_ok  = rd_pop && !empty;
      push_ok = wr_valid && (!full || rd_pop);
      ovf_evt = wr_valid && full && !rd_pop;
      udf_evt = rd_pop && empty;
      if (push_ok) wr_ptr_n = wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr_n = rd_ptr + PTR_W'(1);
      count_n = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      // New byte becomes head when nothing older survives this edge
      if (push_ok && ((count - CNT_W'(pop_ok)) == '0)) rd_data_n = wr_data;
      else if (count_n != '0)                          rd_data_n = mem[rd_ptr_n];
    end
    empty_n     = (count_n == '0);
    full_n      = (count_n == CNT_W'(DEPTH));
    hw_base     = clr_flags ? '0 : hiwater;
    hiwater_n   = (count_n > hw_base) ? count_n : hw_base;
    overflow_n  = (overflow && !clr_flags) || ovf_evt;
    underflow_n = (underflow && !clr_flags) || udf_evt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_data   <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      hiwater   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      rd_data   <= rd_data_n;
      empty     <= empty_n;
      full      <= full_n;
      hiwater   <= hiwater_n;
      overflow  <= overflow_n;
      underflow <= underflow_n;
    end
  end

  // Storage is not reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule
